// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-channel sync, debounce and press/release/long-hold pulses
module switch_debouncer #(
  parameter int g_NUM_SWITCHES   = 4,
  parameter int g_DEBOUNCE_LIMIT = 250000,
  parameter int g_HOLD_LIMIT     = 75000000
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic [g_NUM_SWITCHES-1:0] i_Switches,
  output logic [g_NUM_SWITCHES-1:0] o_Switches,
  output logic [g_NUM_SWITCHES-1:0] o_Pressed,
  output logic [g_NUM_SWITCHES-1:0] o_Released,
  output logic [g_NUM_SWITCHES-1:0] o_Held,
  output logic                      o_Any
);

  localparam int DW = $clog2(g_DEBOUNCE_LIMIT);
  localparam int HW = $clog2(g_HOLD_LIMIT);
  localparam logic [DW-1:0] DEB_LAST  = DW'(g_DEBOUNCE_LIMIT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(g_HOLD_LIMIT - 1);

  for (genvar i = 0; i < g_NUM_SWITCHES; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          stable;
    logic          armed;
    logic          pressed;
    logic          released;
    logic          held;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
        s1       <= 1'b0;
        s2       <= 1'b0;
        stable   <= 1'b0;
        armed    <= 1'b0;
        pressed  <= 1'b0;
        released <= 1'b0;
        held     <= 1'b0;
        dcnt     <= '0;
        hcnt     <= '0;
      end else begin
        s1       <= i_Switches[i];
        s2       <= s1;
        pressed  <= 1'b0;
        released <= 1'b0;
        held     <= 1'b0;

        // Any cycle where s2 agrees with the accepted level restarts the count.
        if (s2 == stable) begin
          dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
          stable   <= s2;
          dcnt     <= '0;
          pressed  <= s2;
          released <= ~s2;
        end else begin
          dcnt <= dcnt + DW'(1);
        end

        // Disarming after the pulse leaves hcnt parked until the next release.
        if (!stable) begin
          hcnt  <= '0;
          armed <= 1'b1;
        end else if (armed) begin
          if (hcnt == HOLD_LAST) begin
            held  <= 1'b1;
            armed <= 1'b0;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
      end
    end

    assign o_Switches[i] = stable;
    assign o_Pressed[i]  = pressed;
    assign o_Released[i] = released;
    assign o_Held[i]     = held;
  end

  assign o_Any = |o_Switches;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - directed self-checking bench for switch_debouncer
module tb_switch_debouncer;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] sw_out;
  logic [3:0] pressed;
  logic [3:0] released;
  logic [3:0] held;
  logic       any;

  int n_compared   = 0;
  int n_mismatched = 0;

  switch_debouncer #(
    .g_NUM_SWITCHES  (4),
    .g_DEBOUNCE_LIMIT(4),
    .g_HOLD_LIMIT    (10)
  ) dut (
    .i_Clk     (clk),
    .i_Reset   (rst),
    .i_Switches(sw),
    .o_Switches(sw_out),
    .o_Pressed (pressed),
    .o_Released(released),
    .o_Held    (held),
    .o_Any     (any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are observed 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int first;
    int cnt;
    logic [3:0] pval;
    rst = 1'b0;
    sw  = 4'hF;
    #2;
    rst = 1'b1;
    #1;
    n_compared++;
    if ({sw_out, pressed, released, held, any} !== 17'd0) begin
      n_mismatched++;
      $display("FAIL reset_async: got %h expected 0", {sw_out, pressed, released, held, any});
    end
    for (int t = 1; t <= 4; t++) begin
      tick();
      n_compared++;
      if ({sw_out, pressed, released, held, any} !== 17'd0) begin
        n_mismatched++;
        $display("FAIL reset_hold_t%0d: got %h expected 0", t, {sw_out, pressed, released, held, any});
      end
    end
    rst = 1'b0;
    first = 0; cnt = 0; pval = '0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (pressed !== 4'h0) begin
        cnt++;
        if (first == 0) begin first = t; pval = pressed; end
      end
    end
    n_compared++;
    if (first !== 6) begin
      n_mismatched++;
      $display("FAIL reset_press_tick: got %0d expected 6", first);
    end
    n_compared++;
    if (cnt !== 1 || pval !== 4'hF) begin
      n_mismatched++;
      $display("FAIL reset_press_once: got count %0d value %h expected count 1 value f", cnt, pval);
    end
    sw = 4'h0;
    first = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (released === 4'hF && first == 0) first = t;
    end
    n_compared++;
    if (first !== 6) begin
      n_mismatched++;
      $display("FAIL reset_release_tick: got %0d expected 6", first);
    end
  endtask

  task automatic test_clean_press();
    int first;
    int cnt;
    sw = 4'b0001;
    first = 0; cnt = 0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 5) begin
        n_compared++;
        if (sw_out[0] !== 1'b0) begin
          n_mismatched++;
          $display("FAIL clean_level_before: got %b expected 0", sw_out[0]);
        end
      end
      if (t == 6) begin
        n_compared++;
        if (sw_out[0] !== 1'b1) begin
          n_mismatched++;
          $display("FAIL clean_level_after: got %b expected 1", sw_out[0]);
        end
      end
      if (pressed[0]) begin cnt++; if (first == 0) first = t; end
    end
    n_compared++;
    if (first !== 6 || cnt !== 1) begin
      n_mismatched++;
      $display("FAIL clean_press: got tick %0d count %0d expected tick 6 count 1", first, cnt);
    end
    sw = 4'b0000;
    first = 0; cnt = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (released[0]) begin cnt++; if (first == 0) first = t; end
    end
    n_compared++;
    if (first !== 6 || cnt !== 1) begin
      n_mismatched++;
      $display("FAIL clean_release: got tick %0d count %0d expected tick 6 count 1", first, cnt);
    end
  endtask

  task automatic test_bounce();
    int first;
    int cnt;
    int early;
    logic [7:0] pattern;
    pattern = 8'b0011_0011;
    first = 0; cnt = 0; early = 0;
    for (int t = 1; t <= 15; t++) begin
      sw = (t <= 8) ? {2'b00, pattern[t-1], 1'b0} : 4'b0010;
      tick();
      if (pressed[1]) begin cnt++; if (first == 0) first = t; end
      if (t < 14 && (pressed[1] || released[1])) early++;
    end
    n_compared++;
    if (early !== 0) begin
      n_mismatched++;
      $display("FAIL bounce_quiet: got %0d pulses expected 0", early);
    end
    n_compared++;
    if (first !== 14 || cnt !== 1) begin
      n_mismatched++;
      $display("FAIL bounce_press: got tick %0d count %0d expected tick 14 count 1", first, cnt);
    end
    sw = 4'b0000;
    for (int t = 1; t <= 8; t++) tick();
  endtask

  task automatic test_hold();
    int p_tick;
    int h_tick;
    int h_cnt;
    int r_cnt;
    int p_cnt;
    sw = 4'b0100;
    p_tick = 0; h_tick = 0; h_cnt = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (pressed[2] && p_tick == 0) p_tick = t;
      if (held[2]) begin h_cnt++; if (h_tick == 0) h_tick = t; end
    end
    n_compared++;
    if (p_tick !== 6 || h_tick !== 16 || h_cnt !== 1) begin
      n_mismatched++;
      $display("FAIL hold_long: got press %0d held %0d count %0d expected press 6 held 16 count 1",
               p_tick, h_tick, h_cnt);
    end
    sw = 4'b0000;
    r_cnt = 0; h_cnt = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (released[2]) r_cnt++;
      if (held[2]) h_cnt++;
    end
    n_compared++;
    if (r_cnt !== 1 || h_cnt !== 0) begin
      n_mismatched++;
      $display("FAIL hold_release: got released %0d held %0d expected 1 and 0", r_cnt, h_cnt);
    end
    p_cnt = 0; r_cnt = 0; h_cnt = 0;
    for (int t = 1; t <= 20; t++) begin
      sw = (t <= 8) ? 4'b0100 : 4'b0000;
      tick();
      if (pressed[2]) p_cnt++;
      if (released[2]) r_cnt++;
      if (held[2]) h_cnt++;
    end
    n_compared++;
    if (p_cnt !== 1 || r_cnt !== 1 || h_cnt !== 0) begin
      n_mismatched++;
      $display("FAIL hold_short: got pressed %0d released %0d held %0d expected 1 1 0",
               p_cnt, r_cnt, h_cnt);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] p6;
    logic       a6;
    logic [3:0] r6;
    logic       ar6;
    sw = 4'b1001;
    p6 = 'x; a6 = 1'bx;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 6) begin p6 = pressed; a6 = any; end
    end
    n_compared++;
    if (p6 !== 4'b1001 || a6 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL simul_press: got pressed %b any %b expected 1001 1", p6, a6);
    end
    sw = 4'b1000;
    r6 = 'x; ar6 = 1'bx;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 6) begin r6 = released; ar6 = any; end
    end
    n_compared++;
    if (r6 !== 4'b0001 || ar6 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL simul_release: got released %b any %b expected 0001 1", r6, ar6);
    end
    sw = 4'b0000;
    for (int t = 1; t <= 10; t++) tick();
    n_compared++;
    if (any !== 1'b0) begin
      n_mismatched++;
      $display("FAIL simul_idle_any: got %b expected 0", any);
    end
  endtask

  task automatic test_reset_mid_hold();
    int first;
    int h_cnt;
    sw = 4'b0100;
    h_cnt = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (held[2]) h_cnt++;
    end
    #2;
    rst = 1'b1;
    #1;
    n_compared++;
    if ({sw_out, pressed, released, held, any} !== 17'd0) begin
      n_mismatched++;
      $display("FAIL midhold_async: got %h expected 0", {sw_out, pressed, released, held, any});
    end
    for (int t = 1; t <= 3; t++) begin
      tick();
      if (held[2]) h_cnt++;
    end
    rst = 1'b0;
    first = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (held[2]) h_cnt++;
      if (pressed[2] && first == 0) first = t;
    end
    n_compared++;
    if (first !== 6) begin
      n_mismatched++;
      $display("FAIL midhold_repress: got tick %0d expected 6", first);
    end
    n_compared++;
    if (h_cnt !== 0) begin
      n_mismatched++;
      $display("FAIL midhold_no_held: got %0d expected 0", h_cnt);
    end
    sw = 4'b0000;
    for (int t = 1; t <= 8; t++) tick();
  endtask

  initial begin
    rst = 1'b0;
    sw  = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold();
    test_simultaneous();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
